axis_dac_gearbox: RTL and testbench

- Downstream stage of the URAM play-pointer streamer.
- Consumes the 512-bit AXIS waveform stream (axis_0) and narrows it to the DAC-tile sample width, emitting LSB slice first.
- Once primed, it keeps DAC data flowing continuously: when upstream starves, it substitutes zero samples and counts underruns for GPIO readback.
- Sits between the play-pointer AXIS master and the RF data converter DAC AXIS slave, in the same axis_clk domain.

---
 rtl/axis_dac_gearbox.sv | 109 ++++++++++
 tb/tb_axis_dac_gearbox.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axis_dac_gearbox.sv
// Narrows the wide AXIS waveform stream to DAC-tile slices (LSB slice first).
// Once primed, the output never stalls for lack of input: zero slices fill any gap and are counted.
module axis_dac_gearbox #(
  parameter int unsigned IN_W  = 512,
  parameter int unsigned OUT_W = 256,
  parameter int unsigned CNT_W = 32
) (
  input  logic             axis_clk,
  input  logic             axis_aresetn,
  input  logic             en,
  input  logic             clr_underrun,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic             underrun_sticky
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e                     r_state;
  logic [IN_W-1:0]            r_hold_data;
  logic                       r_hold_valid;
  logic [IDX_W-1:0]           r_idx;
  logic [CNT_W-1:0]           r_underrun_cnt;
  logic                       r_underrun_sticky;

  logic [RATIO-1:0][OUT_W-1:0] w_slices;
  logic                       w_cons;
  logic                       w_last;
  logic                       w_accept;
  logic                       w_underrun;

  assign w_slices   = r_hold_data;
  assign w_cons     = (r_state == StRun) & m_axis_tready;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_underrun = w_cons & ~r_hold_valid;

  // A new word may only land when the holding register is empty or draining its last slice now.
  assign s_axis_tready = en & (r_state != StIdle) & (~r_hold_valid | (w_last & w_cons));
  assign w_accept      = s_axis_tvalid & s_axis_tready;

  assign m_axis_tvalid   = (r_state == StRun);
  assign m_axis_tdata    = r_hold_valid ? w_slices[r_idx] : '0;
  assign underrun_cnt    = r_underrun_cnt;
  assign underrun_sticky = r_underrun_sticky;

  always_ff @(posedge axis_clk) begin
    if (!axis_aresetn) begin
      r_underrun_cnt    <= '0;
      r_underrun_sticky <= 1'b0;
    end else if (clr_underrun) begin
      // A simultaneous underrun survives the clear.
      r_underrun_cnt    <= w_underrun ? CNT_W'(1) : '0;
      r_underrun_sticky <= w_underrun;
    end else if (w_underrun) begin
      if (r_underrun_cnt != '1) r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
      r_underrun_sticky <= 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_aresetn) begin
      r_state      <= StIdle;
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
      r_idx        <= '0;
    end else if (!en) begin
      r_state      <= StIdle;
      r_hold_valid <= 1'b0;
      r_idx        <= '0;
    end else begin
      unique case (r_state)
        StIdle: r_state <= StPrime;
        StPrime: begin
          if (w_accept) begin
            r_hold_data  <= s_axis_tdata;
            r_hold_valid <= 1'b1;
            r_idx        <= '0;
            r_state      <= StRun;
          end
        end
        StRun: begin
          if (w_accept) begin
            r_hold_data  <= s_axis_tdata;
            r_hold_valid <= 1'b1;
            r_idx        <= '0;
          end else if (w_cons && r_hold_valid) begin
            if (w_last) begin
              r_idx        <= '0;
              r_hold_valid <= 1'b0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_dac_gearbox.sv
// Randomized + directed bench for axis_dac_gearbox; a slice-queue reference model feeds a
// per-cycle checker that compares every output on the falling edge.
module tb_axis_dac_gearbox;

  localparam int IN_W  = 512;
  localparam int OUT_W = 256;
  localparam int CNT_W = 4;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [IN_W-1:0]  s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [OUT_W-1:0] m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic [CNT_W-1:0] cnt;
  logic             sticky;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axis_dac_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
    .axis_clk        (clk),
    .axis_aresetn    (rst_n),
    .en              (en),
    .clr_underrun    (clr),
    .s_axis_tdata    (s_tdata),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tready   (s_tready),
    .m_axis_tdata    (m_tdata),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tready   (m_tready),
    .underrun_cnt    (cnt),
    .underrun_sticky (sticky)
  );

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: remaining slices of the held word, plus a coarse run phase.
  localparam int PhIdle = 0, PhPrime = 1, PhRun = 2;
  logic [OUT_W-1:0] exp_q[$];
  int               m_ph = PhIdle;
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_sticky = 1'b0;
  bit               rst_prev = 1'b0;
  bit               run, cons, rdy, und;
  logic [OUT_W-1:0] exp_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (rst_prev) begin
        chk("rst_tvalid", OUT_W'(m_tvalid), '0);
        chk("rst_tdata", m_tdata, '0);
        chk("rst_tready", OUT_W'(s_tready), '0);
        chk("rst_cnt", OUT_W'(cnt), '0);
        chk("rst_sticky", OUT_W'(sticky), '0);
      end
      exp_q.delete();
      m_ph = PhIdle;
      m_cnt = '0;
      m_sticky = 1'b0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      run   = (m_ph == PhRun);
      cons  = run && m_tready;
      rdy   = en && (m_ph != PhIdle) && (exp_q.size() == 0 || (exp_q.size() == 1 && cons));
      exp_d = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("m_tvalid", OUT_W'(m_tvalid), OUT_W'(run));
      chk("m_tdata", m_tdata, exp_d);
      chk("s_tready", OUT_W'(s_tready), OUT_W'(rdy));
      chk("underrun_cnt", OUT_W'(cnt), OUT_W'(m_cnt));
      chk("underrun_sticky", OUT_W'(sticky), OUT_W'(m_sticky));
      // Advance the model across the coming rising edge.
      und = cons && (exp_q.size() == 0);
      if (clr) begin
        m_cnt    = und ? CNT_W'(1) : '0;
        m_sticky = und;
      end else if (und) begin
        if (m_cnt != '1) m_cnt = m_cnt + 1;
        m_sticky = 1'b1;
      end
      if (cons && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s_tvalid && rdy)
        for (int i = 0; i < RATIO; i++) exp_q.push_back(s_tdata[i*OUT_W +: OUT_W]);
      if (!en) begin
        m_ph = PhIdle;
        exp_q.delete();
      end else if (m_ph == PhIdle) begin
        m_ph = PhPrime;
      end else if (m_ph == PhPrime && s_tvalid && rdy) begin
        m_ph = PhRun;
      end
    end
  end

  function automatic logic [IN_W-1:0] rnd_word();
    logic [IN_W-1:0] w;
    for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one word and returns just after the edge that accepted it.
  task automatic send(input logic [IN_W-1:0] d);
    int n;
    n = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 200);
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout at %0t: got no s_tready expected handshake", $time);
    end
    tick(1);
    s_tvalid = 1'b0;
  endtask

  initial begin
    tick(4);
    rst_n = 1'b1;
    en = 1'b1;
    tick(20);
    // Back-to-back A/B then C/D, then starve into underruns.
    send({{64{4'hB}}, {64{4'hA}}});
    send({{64{4'hD}}, {64{4'hC}}});
    tick(4);
    for (int i = 0; i < 3; i++) send(rnd_word());
    tick(14);
    send(rnd_word());
    tick(4);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(24);
    // Stall on slice 1.
    send(rnd_word());
    tick(1);
    m_tready = 1'b0;
    tick(5);
    m_tready = 1'b1;
    tick(3);
    // Drop enable on slice 0 of a word.
    send(rnd_word());
    en = 1'b0;
    tick(2);
    en = 1'b1;
    send(rnd_word());
    tick(3);
    // Reset in the middle of a word.
    send(rnd_word());
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      en       = ($urandom_range(0, 63) != 0);
      clr      = ($urandom_range(0, 31) == 0);
      s_tvalid = $urandom_range(0, 1);
      m_tready = ($urandom_range(0, 3) != 0);
      s_tdata  = rnd_word();
      tick(1);
    end
    s_tvalid = 1'b0;
    clr = 1'b0;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
